// File: rtl/alu.sv
// 4-bit execution-stage ALU: combinational opcode decode feeding a result
// register and a status-flag register {N, V, C, Z}.
module alu (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [3:0] ivInstruccion,
    input  logic [3:0] ivRegistroA,
    input  logic [3:0] ivRegistroB,
    output logic [3:0] ovResultado,
    output logic [3:0] ovFlags
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_ROL   = 4'b1010;
    localparam logic [3:0] OP_ROR   = 4'b1011;
    localparam logic [3:0] OP_INC   = 4'b1100;
    localparam logic [3:0] OP_DEC   = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] OP_CMP   = 4'b1111;

    logic [3:0] result_q, result_d;
    logic [3:0] flags_q,  flags_d;
    logic [4:0] sum_w, diff_w;
    logic [3:0] res_w;
    logic       carry_w, ovf_w;

    // Shared adder/subtractor; bit 4 carries the carry-out or the borrow.
    assign sum_w  = {1'b0, ivRegistroA} + {1'b0, ivRegistroB};
    assign diff_w = {1'b0, ivRegistroA} - {1'b0, ivRegistroB};

    // Opcode decode: raw result plus carry and overflow for every encoding.
    always_comb begin
        res_w   = 4'b0000;
        carry_w = 1'b0;
        ovf_w   = 1'b0;
        case (ivInstruccion)
            OP_ADD: begin
                res_w   = sum_w[3:0];
                carry_w = sum_w[4];
                ovf_w   = (ivRegistroA[3] == ivRegistroB[3]) && (sum_w[3] != ivRegistroA[3]);
            end
            OP_SUB, OP_CMP: begin
                res_w   = diff_w[3:0];
                carry_w = diff_w[4];
                ovf_w   = (ivRegistroA[3] != ivRegistroB[3]) && (diff_w[3] != ivRegistroA[3]);
            end
            OP_AND:   res_w = ivRegistroA & ivRegistroB;
            OP_OR:    res_w = ivRegistroA | ivRegistroB;
            OP_XOR:   res_w = ivRegistroA ^ ivRegistroB;
            OP_NOT:   res_w = ~ivRegistroA;
            OP_NAND:  res_w = ~(ivRegistroA & ivRegistroB);
            OP_NOR:   res_w = ~(ivRegistroA | ivRegistroB);
            OP_SHL: begin
                res_w   = {ivRegistroA[2:0], 1'b0};
                carry_w = ivRegistroA[3];
                ovf_w   = ivRegistroA[3] ^ ivRegistroA[2];
            end
            OP_SHR: begin
                res_w   = {1'b0, ivRegistroA[3:1]};
                carry_w = ivRegistroA[0];
            end
            OP_ROL: begin
                res_w   = {ivRegistroA[2:0], ivRegistroA[3]};
                carry_w = ivRegistroA[3];
            end
            OP_ROR: begin
                res_w   = {ivRegistroA[0], ivRegistroA[3:1]};
                carry_w = ivRegistroA[0];
            end
            OP_INC: begin
                res_w   = ivRegistroA + 4'd1;
                carry_w = (ivRegistroA == 4'b1111);
                ovf_w   = (ivRegistroA == 4'b0111);
            end
            OP_DEC: begin
                res_w   = ivRegistroA - 4'd1;
                carry_w = (ivRegistroA == 4'b0000);
                ovf_w   = (ivRegistroA == 4'b1000);
            end
            OP_PASSB: res_w = ivRegistroB;
            default:  res_w = 4'b0000;
        endcase
    end

    // Flags always follow the computed value; CMP keeps the previous result.
    always_comb begin
        flags_d  = {res_w[3], ovf_w, carry_w, (res_w == 4'b0000)};
        result_d = (ivInstruccion == OP_CMP) ? result_q : res_w;
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            result_q <= 4'b0000;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign ovResultado = result_q;
    assign ovFlags     = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit ALU; expectations are hand-computed.
module tb_alu;

    logic       iClk;
    logic       iReset;
    logic [3:0] ivInstruccion;
    logic [3:0] ivRegistroA;
    logic [3:0] ivRegistroB;
    logic [3:0] ovResultado;
    logic [3:0] ovFlags;

    int checks = 0;
    int errors = 0;

    alu dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .ivInstruccion (ivInstruccion),
        .ivRegistroA   (ivRegistroA),
        .ivRegistroB   (ivRegistroB),
        .ovResultado   (ovResultado),
        .ovFlags       (ovFlags)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Drive one operation on the falling edge and return 1 time unit after
    // the capturing rising edge.
    task automatic apply(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge iClk);
        ivInstruccion = op;
        ivRegistroA   = a;
        ivRegistroB   = b;
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ovResultado !== 4'b0000 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_initial: got R=%b F=%b, want R=0000 F=0000", ovResultado, ovFlags);
        end
        @(negedge iClk);
        iReset = 1'b0;
        // CMP straight out of reset: result must remain the cleared value.
        apply(4'b1111, 4'b0001, 4'b0010);
        checks++;
        if (ovResultado !== 4'b0000 || ovFlags !== 4'b1010) begin
            errors++;
            $display("FAIL cmp_after_reset: got R=%b F=%b, want R=0000 F=1010", ovResultado, ovFlags);
        end
    endtask

    task automatic test_add();
        logic [3:0] a_v [3]  = '{4'b0001, 4'b0111, 4'b1111};
        logic [3:0] b_v [3]  = '{4'b0001, 4'b0001, 4'b0001};
        logic [3:0] r_v [3]  = '{4'b0010, 4'b1000, 4'b0000};
        logic [3:0] f_v [3]  = '{4'b0000, 4'b1100, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            apply(4'b0000, a_v[i], b_v[i]);
            checks++;
            if (ovResultado !== r_v[i] || ovFlags !== f_v[i]) begin
                errors++;
                $display("FAIL add_%0d: got R=%b F=%b, want R=%b F=%b", i, ovResultado, ovFlags, r_v[i], f_v[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [3:0] a_v [3]  = '{4'b0011, 4'b0001, 4'b1000};
        logic [3:0] b_v [3]  = '{4'b0011, 4'b0010, 4'b0001};
        logic [3:0] r_v [3]  = '{4'b0000, 4'b1111, 4'b0111};
        logic [3:0] f_v [3]  = '{4'b0001, 4'b1010, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            apply(4'b0001, a_v[i], b_v[i]);
            checks++;
            if (ovResultado !== r_v[i] || ovFlags !== f_v[i]) begin
                errors++;
                $display("FAIL sub_%0d: got R=%b F=%b, want R=%b F=%b", i, ovResultado, ovFlags, r_v[i], f_v[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0] op_v [7] = '{4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b0101, 4'b1110};
        logic [3:0] r_v  [7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b0011, 4'b1010};
        logic [3:0] f_v  [7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            apply(op_v[i], 4'b1100, 4'b1010);
            checks++;
            if (ovResultado !== r_v[i] || ovFlags !== f_v[i]) begin
                errors++;
                $display("FAIL logic_op%b: got R=%b F=%b, want R=%b F=%b", op_v[i], ovResultado, ovFlags, r_v[i], f_v[i]);
            end
        end
        // Bitwise result zero must raise Z.
        apply(4'b0010, 4'b0101, 4'b1010);
        checks++;
        if (ovResultado !== 4'b0000 || ovFlags !== 4'b0001) begin
            errors++;
            $display("FAIL logic_and_zero: got R=%b F=%b, want R=0000 F=0001", ovResultado, ovFlags);
        end
    endtask

    task automatic test_shift();
        logic [3:0] op_v [4] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011};
        logic [3:0] r_v  [4] = '{4'b0010, 4'b0100, 4'b0011, 4'b1100};
        logic [3:0] f_v  [4] = '{4'b0110, 4'b0010, 4'b0010, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            apply(op_v[i], 4'b1001, 4'b1111);
            checks++;
            if (ovResultado !== r_v[i] || ovFlags !== f_v[i]) begin
                errors++;
                $display("FAIL shift_op%b: got R=%b F=%b, want R=%b F=%b", op_v[i], ovResultado, ovFlags, r_v[i], f_v[i]);
            end
        end
        // SHL of 0110: no carry-out but sign change -> R=1100, N=1, V=1.
        apply(4'b1000, 4'b0110, 4'b0000);
        checks++;
        if (ovResultado !== 4'b1100 || ovFlags !== 4'b1100) begin
            errors++;
            $display("FAIL shl_0110: got R=%b F=%b, want R=1100 F=1100", ovResultado, ovFlags);
        end
    endtask

    task automatic test_incdec();
        logic [3:0] op_v [4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
        logic [3:0] a_v  [4] = '{4'b1111, 4'b0000, 4'b0111, 4'b1000};
        logic [3:0] r_v  [4] = '{4'b0000, 4'b1111, 4'b1000, 4'b0111};
        logic [3:0] f_v  [4] = '{4'b0011, 4'b1010, 4'b1100, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            apply(op_v[i], a_v[i], 4'b0101);
            checks++;
            if (ovResultado !== r_v[i] || ovFlags !== f_v[i]) begin
                errors++;
                $display("FAIL incdec_%0d: got R=%b F=%b, want R=%b F=%b", i, ovResultado, ovFlags, r_v[i], f_v[i]);
            end
        end
    endtask

    task automatic test_cmp();
        apply(4'b0000, 4'b0011, 4'b0011);
        checks++;
        if (ovResultado !== 4'b0110 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL cmp_setup_add: got R=%b F=%b, want R=0110 F=0000", ovResultado, ovFlags);
        end
        apply(4'b1111, 4'b0101, 4'b0101);
        checks++;
        if (ovResultado !== 4'b0110 || ovFlags !== 4'b0001) begin
            errors++;
            $display("FAIL cmp_equal: got R=%b F=%b, want R=0110 F=0001", ovResultado, ovFlags);
        end
        apply(4'b1111, 4'b1000, 4'b0001);
        checks++;
        if (ovResultado !== 4'b0110 || ovFlags !== 4'b0100) begin
            errors++;
            $display("FAIL cmp_overflow: got R=%b F=%b, want R=0110 F=0100", ovResultado, ovFlags);
        end
    endtask

    task automatic test_back_to_back();
        apply(4'b0000, 4'b0010, 4'b0011);
        checks++;
        if (ovResultado !== 4'b0101 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_add: got R=%b F=%b, want R=0101 F=0000", ovResultado, ovFlags);
        end
        // Mid-cycle input change must not reach the outputs before the edge.
        ivInstruccion = 4'b1110;
        ivRegistroB   = 4'b1001;
        #2;
        checks++;
        if (ovResultado !== 4'b0101 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL midcycle_hold: got R=%b F=%b, want R=0101 F=0000", ovResultado, ovFlags);
        end
        @(posedge iClk);
        #1;
        checks++;
        if (ovResultado !== 4'b1001 || ovFlags !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_passb: got R=%b F=%b, want R=1001 F=1000", ovResultado, ovFlags);
        end
    endtask

    task automatic test_async_reset();
        apply(4'b0000, 4'b0111, 4'b0001);
        checks++;
        if (ovResultado !== 4'b1000 || ovFlags !== 4'b1100) begin
            errors++;
            $display("FAIL areset_setup: got R=%b F=%b, want R=1000 F=1100", ovResultado, ovFlags);
        end
        #2;
        iReset = 1'b1;
        #1;
        checks++;
        if (ovResultado !== 4'b0000 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL areset_immediate: got R=%b F=%b, want R=0000 F=0000", ovResultado, ovFlags);
        end
        @(posedge iClk);
        #1;
        checks++;
        if (ovResultado !== 4'b0000 || ovFlags !== 4'b0000) begin
            errors++;
            $display("FAIL areset_held: got R=%b F=%b, want R=0000 F=0000", ovResultado, ovFlags);
        end
        @(negedge iClk);
        iReset = 1'b0;
        @(posedge iClk);
        #1;
        checks++;
        if (ovResultado !== 4'b1000 || ovFlags !== 4'b1100) begin
            errors++;
            $display("FAIL areset_release: got R=%b F=%b, want R=1000 F=1100", ovResultado, ovFlags);
        end
    endtask

    initial begin
        iReset        = 1'b1;
        ivInstruccion = 4'b0000;
        ivRegistroA   = 4'b0000;
        ivRegistroB   = 4'b0000;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_incdec();
        test_cmp();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational 4-bit arithmetic/logic unit with registered outputs, the execution stage of the team's 4-bit microcontroller datapath. Each clock edge it captures the result of the opcode on `ivInstruccion` applied to `ivRegistroA`/`ivRegistroB`, plus a 4-bit status-flag vector consumed by the branch/condition logic.

## Interface
- No parameters; datapath width fixed at 4 bits.
- `iClk` input 1: system clock, rising-edge active.
- `iReset` input 1: asynchronous, active-high reset.
- `ivInstruccion` input 4: opcode, table below.
- `ivRegistroA` input 4: operand A, unsigned or two's complement.
- `ivRegistroB` input 4: operand B.
- `ovResultado` output 4: registered result.
- `ovFlags` output 4: registered flags; [0]=Z zero, [1]=C carry/borrow/shift-out, [2]=V signed overflow, [3]=N sign (result bit 3).

## Operation
- Opcodes; R = result, A/B = operands:
  - 0000 ADD: R=A+B; C=carry-out of bit 3; V=signed overflow.
  - 0001 SUB: R=A-B; C=1 on borrow (A<B unsigned); V=signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR, 0110 NAND, 0111 NOR: bitwise; C=0, V=0.
  - 0101 NOT: R=~A; C=0, V=0.
  - 1000 SHL: R={A[2:0],0}; C=A[3]; V=A[3]^A[2].
  - 1001 SHR (logical): R={0,A[3:1]}; C=A[0]; V=0.
  - 1010 ROL: R={A[2:0],A[3]}; C=A[3]; V=0.
  - 1011 ROR: R={A[0],A[3:1]}; C=A[0]; V=0.
  - 1100 INC: R=A+1; C=1 if A=1111; V=1 if A=0111.
  - 1101 DEC: R=A-1; C=1 (borrow) if A=0000; V=1 if A=1000.
  - 1110 PASSB: R=B; C=0, V=0.
  - 1111 CMP: flags computed exactly as SUB; `ovResultado` holds its previous value.
- Z=1 iff the 4-bit R is 0000; N=R[3]. For CMP, Z and N are taken from the internal difference A-B.
- All arithmetic is modulo 16; carries beyond bit 3 appear only in C.
- Operand B is ignored for the unary opcodes: NOT, shifts, rotates, INC, DEC.
- No undefined opcodes; all 16 encodings are decoded.

## Timing
- Result and flags are computed combinationally and registered on the rising edge of `iClk`; latency is 1 cycle from input change to valid outputs.
- New opcode/operands are accepted every cycle; no handshake and no stall.
- `iReset`=1 asynchronously forces `ovResultado`=0000 and `ovFlags`=0000, independent of the clock, and holds them while asserted.
- First capture occurs on the first rising edge after `iReset` deasserts.
- Inputs changing mid-cycle have no effect on outputs until the next edge.
- CMP leaves `ovResultado` unchanged; after reset that value is 0000.

## Test plan
- Reset: assert `iReset` mid-cycle with nonzero outputs -> both outputs 0000 immediately, without waiting for a clock edge; they stay 0000 while asserted.
- ADD 0001+0001 -> after one edge R=0010, flags 0000. ADD 0111+0001 -> R=1000, V=1, N=1 (flags 1100). ADD 1111+0001 -> R=0000, Z=1, C=1 (flags 0011).
- SUB 0011-0011 -> R=0000, flags 0001. SUB 0001-0010 -> R=1111, C=1, N=1 (flags 1010). SUB 1000-0001 -> R=0111, V=1 (flags 0100).
- Logic, A=1100, B=1010 -> AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, NOT 0011, PASSB 1010. C and V are 0 for all; N and Z follow R.
- Shift/rotate, A=1001 -> SHL R=0010 C=1 V=1; SHR R=0100 C=1; ROL R=0011 C=1; ROR R=1100 C=1 N=1.
- INC 1111 -> R=0000, flags 0011. DEC 0000 -> R=1111, flags 1010. CMP A=0101, B=0101 after an ADD result 0110 -> R stays 0110, flags 0001.
